// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose: FSM state encoding, access op encoding and word geometry shared
// by dmem_responder and dmem_array.
// Ports: none (package).

package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with byte-lane writes and a registered read port
//
// Purpose: DEPTH_WORDS x 32 synchronous storage. Storage itself is never
// reset; only the read register is, so the responder's read_data output
// can return to 0 asynchronously.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset (read register only)
//   wr_lanes  in   per-byte write enables for wr_index
//   wr_index  in   word index to write
//   wr_data   in   write data, lane i = wr_data[8i+7:8i]
//   rd_en     in   capture mem[rd_index] into rd_data
//   rd_clear  in   load 0 into rd_data (takes priority over rd_en)
//   rd_index  in   word index to read
//   rd_data   out  registered read data

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WORD_BYTES-1:0]          wr_lanes,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_index,
  input  logic [31:0]                    wr_data,
  input  logic                           rd_en,
  input  logic                           rd_clear,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_index,
  output logic [31:0]                    rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= 32'h0;
    end else if (rd_clear) begin
      rd_data <= 32'h0;
    end else if (rd_en) begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with wait states and error checking
//
// Purpose: memory-side end of the MEM-stage load/store interface. Accepts
// one request at a time, waits WAIT_STATES cycles, then pulses ready for
// one cycle with read data or an error flag.
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   read_enable   in   load request
//   write_enable  in   store request
//   address       in   byte address
//   write_data    in   store data
//   byte_en       in   store lane enables
//   read_data     out  registered load data (0 on error completion)
//   ready         out  one-cycle completion pulse
//   error         out  qualifies ready: access was rejected

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state, next_state;
  logic [3:0]    wait_cnt, wait_cnt_next;
  op_e           op_q;
  logic          err_q;
  logic [AW-1:0] index_q;

  logic          request;
  logic          accept;
  logic          acc_err;
  op_e           acc_op;
  logic [AW-1:0] acc_index;

  logic          enter_resp;
  op_e           resp_op;
  logic          resp_err;
  logic [AW-1:0] resp_index;

  logic [WORD_BYTES-1:0] wr_lanes;
  logic                  rd_en;
  logic                  rd_clear;

  // Requests are taken in IDLE and also on the edge that ends RESP.
  assign request   = read_enable | write_enable;
  assign accept    = request && (state != WAIT);
  assign acc_index = address[ADDR_LSB +: AW];
  assign acc_op    = write_enable ? WRITE : READ;
  assign acc_err   = (address[ADDR_LSB-1:0] != '0)
                   || (address[31:ADDR_LSB+AW] != '0)
                   || (read_enable && write_enable);

  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE, RESP: begin
        if (request) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
          end else begin
            next_state    = WAIT;
            wait_cnt_next = 4'(WAIT_STATES);
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        // Counter hits 0 on the same edge that enters RESP.
        if (wait_cnt <= 4'd1) begin
          next_state    = RESP;
          wait_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      default: begin
        next_state    = IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the response must use the live request rather than the registers.
  assign enter_resp = (next_state == RESP);
  assign resp_op    = accept ? acc_op    : op_q;
  assign resp_err   = accept ? acc_err   : err_q;
  assign resp_index = accept ? acc_index : index_q;

  // Stores commit on the acceptance edge; a later read of the same word
  // therefore always sees the new data.
  assign wr_lanes = (accept && !acc_err && (acc_op == WRITE)) ? byte_en : '0;
  assign rd_en    = enter_resp && !resp_err && (resp_op == READ);
  assign rd_clear = enter_resp && resp_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_lanes (wr_lanes),
    .wr_index (acc_index),
    .wr_data  (write_data),
    .rd_en    (rd_en),
    .rd_clear (rd_clear),
    .rd_index (resp_index),
    .rd_data  (read_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      op_q     <= READ;
      err_q    <= 1'b0;
      index_q  <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        op_q    <= acc_op;
        err_q   <= acc_err;
        index_q <= acc_index;
      end
    end
  end

  assign ready = (state == RESP);
  assign error = ready & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        read_enable, write_enable;
  logic [31:0] address, write_data;
  logic [3:0]  byte_en;
  logic [31:0] read_data;
  logic        ready, error;

  logic        re3, we3;
  logic [31:0] addr3, wdata3;
  logic [3:0]  be3;
  logic [31:0] rdata3;
  logic        ready3, error3;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .byte_en      (byte_en),
    .read_data    (read_data),
    .ready        (ready),
    .error        (error)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .read_enable  (re3),
    .write_enable (we3),
    .address      (addr3),
    .write_data   (wdata3),
    .byte_en      (be3),
    .read_data    (rdata3),
    .ready        (ready3),
    .error        (error3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One access on the WAIT_STATES=1 instance; lat counts edges from
  // acceptance to the first sample with ready high (-1 on timeout).
  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    read_enable  = re;
    write_enable = we;
    address      = addr;
    write_data   = wd;
    byte_en      = be;
    @(posedge clk);
    #1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = 32'hFFFF_FFFE;
    write_data   = 32'h0;
    byte_en      = 4'h0;
    lat = -1;
    rd  = 32'h0;
    er  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        rd  = read_data;
        er  = error;
        break;
      end
    end
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [21];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;
    int          rcyc [4];
    logic [31:0] rdat [4];
    logic [31:0] a3 [4];
    logic [31:0] d3 [4];

    reset = 1'b0;
    read_enable = 1'b0; write_enable = 1'b0; address = 32'h0; write_data = 32'h0; byte_en = 4'h0;
    re3 = 1'b0; we3 = 1'b0; addr3 = 32'h0; wdata3 = 32'h0; be3 = 4'h0;
    rcyc = '{0, 0, 0, 0};
    rdat = '{32'h0, 32'h0, 32'h0, 32'h0};

    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_rdata", read_data, 32'h0);
    check("reset_ready3", 32'(ready3), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //          re    we    addr          wd             be     err   chk   exp_rd
    vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,   32'h000000AA, 4'h1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[4]  = '{1'b0, 1'b1, 32'h10,   32'h12345678, 4'h0, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[5]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[6]  = '{1'b1, 1'b0, 32'h12,   32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[8]  = '{1'b1, 1'b1, 32'h10,   32'h0,        4'hF, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[10] = '{1'b0, 1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[11] = '{1'b1, 1'b0, 32'h1000, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h1000, 32'h11111111, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[14] = '{1'b0, 1'b1, 32'hFFC,  32'h0BADF00D, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 1'b0, 32'hFFC,  32'h0,        4'h0, 1'b0, 1'b1, 32'h0BADF00D};
    vecs[16] = '{1'b0, 1'b1, 32'h11,   32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[18] = '{1'b0, 1'b1, 32'h20,   32'h11223344, 4'hF, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[19] = '{1'b0, 1'b1, 32'h20,   32'hAABBCCDD, 4'hA, 1'b0, 1'b1, 32'hDEADBEAA};
    vecs[20] = '{1'b1, 1'b0, 32'h20,   32'h0,        4'h0, 1'b0, 1'b1, 32'hAA22CC44};

    for (int i = 0; i < 21; i++) begin
      access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be, rd, er, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Asynchronous reset while ready is high.
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("pre_reset_ready", 32'(ready), 32'd1);
    check("pre_reset_rdata", read_data, 32'hDEADBEAA);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_ready", 32'(ready), 32'd0);
    check("async_reset_error", 32'(error), 32'd0);
    check("async_reset_rdata", read_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset while a write to 0x20 sits in WAIT.
    @(negedge clk);
    write_enable = 1'b1; address = 32'h20; write_data = 32'h5A5AA5A5; byte_en = 4'hF;
    @(posedge clk);
    #1;
    write_enable = 1'b0; byte_en = 4'h0; write_data = 32'h0;
    reset = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    check("reset_in_wait_no_ready", 32'(seen), 32'd0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("after_reset_latency", 32'(lat), 32'd1);
    check("after_reset_error", 32'(er), 32'd0);
    check("after_reset_rdata", rd, 32'h5A5AA5A5);

    // WAIT_STATES=3 instance: fill four words, then stream four reads.
    a3 = '{32'h40, 32'h44, 32'h48, 32'h4C};
    d3 = '{32'h01010101, 32'h2468ACE0, 32'hF0E1D2C3, 32'h7F00FF80};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we3 = 1'b1; addr3 = a3[i]; wdata3 = d3[i]; be3 = 4'hF;
      @(posedge clk);
      #1;
      we3 = 1'b0; be3 = 4'h0; wdata3 = 32'h0;
      lat = -1;
      er  = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (ready3) begin
          lat = k;
          er  = error3;
          break;
        end
      end
      check($sformatf("ws3_write%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("ws3_write%0d_error", i), 32'(er), 32'd0);
    end

    re3 = 1'b1;
    addr3 = a3[0];
    seen = 0;
    for (int c = 0; c < 60 && seen < 4; c++) begin
      @(posedge clk); #1;
      if (ready3) begin
        rcyc[seen] = c;
        rdat[seen] = rdata3;
        check($sformatf("b2b%0d_error", seen), 32'(error3), 32'd0);
        seen++;
        if (seen < 4) addr3 = a3[seen];
        else re3 = 1'b0;
      end else begin
        addr3 = $urandom;
      end
    end
    check("b2b_count", 32'(seen), 32'd4);
    check("b2b_first_latency", 32'(rcyc[0]), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b%0d_rdata", i), rdat[i], d3[i]);
    end
    for (int i = 1; i < 4; i++) begin
      check($sformatf("b2b%0d_spacing", i), 32'(rcyc[i] - rcyc[i-1]), 32'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core: the memory-side end of the load/store interface driven by the datapath's MEM stage. It accepts one read or write request at a time, models a configurable number of wait states, performs byte-lane writes into an internal word array, and returns a one-cycle `ready` pulse with read data or an error flag. It replaces the behavioural data memory used by the datapath today.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 1: extra cycles between acceptance and response; range 0–15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. Asserting it (0) resets the block immediately; deassertion is synchronised externally.
- `read_enable`  in  1  load request.
- `write_enable`  in  1  store request.
- `address`  in  32  byte address.
- `write_data`  in  32  store data.
- `byte_en`  in  4  store lane enables; bit i selects `write_data[8i+7:8i]`.
- `read_data`  out  32  load data; registered.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `ready`; 1 marks a rejected access.

## Operation
- FSM states:
  - IDLE: accept a request when `read_enable | write_enable`.
  - WAIT: count down a wait counter that is loaded with `WAIT_STATES` at acceptance.
  - RESP: `ready` = 1 for exactly one cycle.
- FSM transitions:
  - IDLE→WAIT when a request is accepted and `WAIT_STATES` > 0.
  - IDLE→RESP when a request is accepted and `WAIT_STATES` = 0.
  - WAIT→RESP when the counter reaches 0.
  - RESP→IDLE, or RESP→WAIT/RESP if a new request is present (back-to-back acceptance in RESP is allowed).
- Acceptance registers `address`, `write_data`, `byte_en` and the op. Inputs are ignored in WAIT. The initiator holds them stable until `ready`, but the block does not depend on that.
- Error conditions, evaluated at acceptance:
  - `address[1:0]` ≠ 0;
  - word index `address[31:2]` ≥ `DEPTH_WORDS`;
  - both enables high.
- An error access completes with the same latency as a normal access: `ready`=1, `error`=1, no array write, `read_data` = 0.
- Writes are committed to the array at the acceptance edge, and only the lanes selected by `byte_en` change. `byte_en` = 0 is a legal no-op write.
- Read data is captured from the array on the edge entering RESP. A read accepted in the RESP cycle of a prior write to the same word returns the new data.
- `read_data` updates only on read completion (valid data, or 0 on error) and holds its value otherwise.
- `error` = 0 whenever `ready` = 0.
- The array is not cleared by reset; its contents are undefined until written.

## Timing
- Reset values: `ready` = 0, `error` = 0, `read_data` = 0, FSM = IDLE, wait counter = 0.
- Latency: a request accepted at edge T0 drives `ready` high during the cycle after edge T0 + `WAIT_STATES`. Example: `WAIT_STATES` = 1 gives `ready` after edge T0+1.
- Throughput: one access per `WAIT_STATES` + 1 cycles with back-to-back requests.
- Reset asserted mid-access:
  - outputs return to reset values asynchronously;
  - the in-flight response is dropped;
  - a write already committed at acceptance remains in the array.
- Simultaneous new request and `ready`: the new request is accepted on the same edge that ends RESP.

## Structure
- Shared package `dmem_pkg` holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the op encoding (READ, WRITE);
  - the `WORD_BYTES` = 4 and `ADDR_LSB` = 2 constants.
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 synchronous storage with a 4-bit lane write enable and a registered read port. The FSM, error check and output registers live in `dmem_responder`.

## Test plan
- Reset: drive `reset` = 0 mid-sim → `ready` = 0, `error` = 0, `read_data` = 0 immediately.
- Basic store/load:
  - write 0xDEADBEEF to 0x10 with `byte_en` = 4'hF; `ready` pulses after edge T0+1 with `error` = 0;
  - read 0x10 → `read_data` = 0xDEADBEEF on `ready`.
- Lane merge:
  - write 0x000000AA to 0x10 with `byte_en` = 4'b0001, then read 0x10 → 0xDEADBEAA;
  - `byte_en` = 0 write → data unchanged.
- Error cases:
  - read 0x12 → `ready` = 1, `error` = 1, `read_data` = 0;
  - both enables high on 0x10 → error, and a later read of 0x10 still returns 0xDEADBEAA;
  - address 4×`DEPTH_WORDS` → error.
- Back-to-back with `WAIT_STATES` = 3: four consecutive reads → `ready` pulses exactly 4 cycles apart; toggling `address` during WAIT does not affect the returned data.
- Reset during WAIT of a write to 0x20:
  - `ready` is never pulsed;
  - after reset release, a read of 0x20 returns the written data with normal latency.
